adc_sample_reader: RTL and testbench

//  Consumer for the VCO-ADC decimated output stream (data_out / data_valid_out).

---
 rtl/adc_sample_reader_if.sv | 27 ++
 rtl/adc_sample_reader.sv | 113 +++++++++++
 tb/tb_adc_sample_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/adc_sample_reader_if.sv
// Handshake/bus bundle for adc_sample_reader: capture control, ADC stream, FIFO read port and status.
interface adc_sample_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  start_in;
  logic [9:0]            count_in;
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid_in;
  logic                  rd_ready_in;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_valid_out;
  logic                  busy_out;
  logic                  done_out;
  logic                  overflow_out;
  logic [ADDR_WIDTH:0]   level_out;

  modport slave (
    input  start_in, count_in, sample_in, sample_valid_in, rd_ready_in,
    output rd_data_out, rd_valid_out, busy_out, done_out, overflow_out, level_out
  );

  modport master (
    output start_in, count_in, sample_in, sample_valid_in, rd_ready_in,
    input  rd_data_out, rd_valid_out, busy_out, done_out, overflow_out, level_out
  );
endinterface

// File: rtl/adc_sample_reader.sv
// Captures a programmed number of ADC samples into a first-word-fall-through FIFO
// that is drained over a valid/ready read port.
module adc_sample_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  adc_sample_reader_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [9:0]            r_remaining;
  logic                  r_rd_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_start_acc;
  logic                  w_cap;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_full;
  logic [ADDR_WIDTH:0]   w_level_nxt;

  // Level MSB alone marks full: occupancy never exceeds DEPTH.
  assign w_full      = r_level[ADDR_WIDTH];
  assign w_start_acc = bus.start_in && (r_state != S_CAPTURE);
  assign w_cap       = (r_state == S_CAPTURE) && bus.sample_valid_in;
  assign w_pop       = r_rd_valid && bus.rd_ready_in;
  assign w_push      = w_cap && (!w_full || w_pop);
  assign w_drop      = w_cap && !w_push;
  assign w_level_nxt = r_level + {{ADDR_WIDTH{1'b0}}, w_push} - {{ADDR_WIDTH{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_remaining <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_start_acc) begin
      // A start flushes the FIFO; any pop or sample in the same cycle is discarded.
      r_remaining <= bus.count_in;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      if (bus.count_in == 10'd0) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_state <= S_CAPTURE;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level    <= w_level_nxt;
      r_rd_valid <= (w_level_nxt != '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      // The window counts ADC samples, stored or dropped.
      if (w_cap) begin
        r_remaining <= r_remaining - 10'd1;
        if (r_remaining == 10'd1) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_data_out  = r_mem[r_rd_ptr];
  assign bus.rd_valid_out = r_rd_valid;
  assign bus.busy_out     = r_busy;
  assign bus.done_out     = r_done;
  assign bus.overflow_out = r_overflow;
  assign bus.level_out    = r_level;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Directed plus randomized bench for adc_sample_reader against a queue-based reference model.
module tb_adc_sample_reader;

  logic clk;
  logic rst;

  adc_sample_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  adc_sample_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  // Reference model: capture window and FIFO as a plain queue.
  logic [31:0] m_q[$];
  bit          m_cap;
  int          m_rem;
  bit          m_done;
  bit          m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cap  = 0;
    m_rem  = 0;
    m_done = 0;
    m_ovf  = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".level"}, 64'(bus.level_out), 64'(m_q.size()));
    check({tag, ".valid"}, 64'(bus.rd_valid_out), 64'(m_q.size() != 0));
    check({tag, ".busy"},  64'(bus.busy_out), 64'(m_cap));
    check({tag, ".done"},  64'(bus.done_out), 64'(m_done));
    check({tag, ".ovf"},   64'(bus.overflow_out), 64'(m_ovf));
  endtask

  // One clock: drive inputs, check head word, clock, advance model, check status.
  task automatic step(input string tag, input logic st, input logic [9:0] cnt,
                      input logic vld, input logic [31:0] smp, input logic rdy);
    bit popped;
    bus.start_in        = st;
    bus.count_in        = cnt;
    bus.sample_valid_in = vld;
    bus.sample_in       = smp;
    bus.rd_ready_in     = rdy;
    if (m_q.size() != 0) check({tag, ".data"}, 64'(bus.rd_data_out), 64'(m_q[0]));
    @(posedge clk);
    if (st && !m_cap) begin
      m_q.delete();
      m_ovf  = 0;
      m_rem  = int'(cnt);
      m_cap  = (cnt != 0);
      m_done = (cnt == 0);
    end else begin
      popped = (m_q.size() != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (m_cap && vld) begin
        if (m_q.size() < 16) m_q.push_back(smp);
        else m_ovf = 1;
        m_rem--;
        if (m_rem == 0) begin
          m_cap  = 0;
          m_done = 1;
        end
      end
    end
    #1;
    check_status(tag);
    bus.start_in        = 1'b0;
    bus.sample_valid_in = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    model_reset();
    bus.start_in        = 1'b0;
    bus.count_in        = '0;
    bus.sample_in       = '0;
    bus.sample_valid_in = 1'b0;
    bus.rd_ready_in     = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_status("reset");

    // Capture 5 samples without reading
    step("t1.start", 1, 10'd5, 0, '0, 0);
    for (int i = 0; i < 5; i++) step("t1.cap", 0, '0, 1, 32'hA0 + 32'(i), 0);
    check("t1.done_final", 64'(bus.done_out), 64'd1);
    check("t1.level_final", 64'(bus.level_out), 64'd5);

    // Drain
    for (int i = 0; i < 7; i++) step("t2.drain", 0, '0, 0, '0, 1);
    check("t2.empty", 64'(bus.rd_valid_out), 64'd0);

    // Overflow: 20 samples into 16 entries
    step("t3.start", 1, 10'd20, 0, '0, 0);
    for (int i = 0; i < 20; i++) step("t3.cap", 0, '0, 1, $urandom, 0);
    check("t3.ovf_final", 64'(bus.overflow_out), 64'd1);
    check("t3.level_final", 64'(bus.level_out), 64'd16);
    for (int i = 0; i < 3; i++) step("t3.partdrain", 0, '0, 0, '0, 1);

    // Full FIFO with simultaneous pop and push
    step("t4.start", 1, 10'd17, 0, '0, 0);
    for (int i = 0; i < 16; i++) step("t4.fill", 0, '0, 1, $urandom, 0);
    step("t4.pushpop", 0, '0, 1, $urandom, 1);
    check("t4.level_full", 64'(bus.level_out), 64'd16);
    check("t4.no_ovf", 64'(bus.overflow_out), 64'd0);
    for (int i = 0; i < 17; i++) step("t4.drain", 0, '0, 0, '0, 1);

    // Zero-count start, then start ignored mid-capture
    step("t5.zero", 1, 10'd0, 1, $urandom, 0);
    check("t5.zero_done", 64'(bus.done_out), 64'd1);
    step("t5.start", 1, 10'd6, 0, '0, 0);
    for (int i = 0; i < 3; i++) step("t5.cap", 0, '0, 1, $urandom, 0);
    step("t5.ignored", 1, 10'd2, 1, $urandom, 0);
    for (int i = 0; i < 3; i++) step("t5.cap2", 0, '0, 1, $urandom, 1);
    step("t5.idle", 0, '0, 0, '0, 1);

    // Async reset mid-capture
    step("t6.start", 1, 10'd8, 0, '0, 0);
    for (int i = 0; i < 3; i++) step("t6.cap", 0, '0, 1, $urandom, 0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_status("t6.async");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("t6.restart", 1, 10'd4, 0, '0, 0);
    for (int i = 0; i < 6; i++) step("t6.cap2", 0, '0, 1, $urandom, i[0]);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), 10'($urandom_range(0, 24)),
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
